// File: rtl/sub_bytes_pipe.sv
// sub_bytes_pipe: multi-lane pipelined AES SubBytes / InvSubBytes built from
// composite-field GF((2^4)^2) arithmetic, with valid/ready flow control on
// both sides so the round controller can stall it.
module sub_bytes_pipe #(
    parameter int LANES       = 4,
    parameter int PIPE_STAGES = 2,
    parameter bit INV_EN      = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [8*LANES-1:0] in_data,
    input  logic               in_inv,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [8*LANES-1:0] out_data,
    output logic               out_inv,
    output logic [1:0]         occupancy
);
    localparam int DW    = 8 * LANES;
    localparam int MW    = 12 * LANES;
    localparam int MID_N = (PIPE_STAGES > 1) ? PIPE_STAGES - 1 : 1;

    // GF(2^2) multiply
    function automatic logic [1:0] gf2_mul(input logic [1:0] q, input logic [1:0] w);
        logic [1:0] k;
        k[1] = (q[1] & w[1]) ^ (q[0] & w[1]) ^ (q[1] & w[0]);
        k[0] = (q[1] & w[1]) ^ (q[0] & w[0]);
        return k;
    endfunction

    // GF(2^2) multiply by the constant phi
    function automatic logic [1:0] gf2_mul_phi(input logic [1:0] q);
        return {q[1] ^ q[0], q[1]};
    endfunction

    // GF(2^4) multiply over GF(2^2)
    function automatic logic [3:0] gf4_mul(input logic [3:0] q, input logic [3:0] w);
        logic [1:0] hh, ll, ss;
        hh = gf2_mul(q[3:2], w[3:2]);
        ll = gf2_mul(q[1:0], w[1:0]);
        ss = gf2_mul(q[3:2] ^ q[1:0], w[3:2] ^ w[1:0]);
        return {ss ^ ll, gf2_mul_phi(hh) ^ ll};
    endfunction

    // GF(2^4) square
    function automatic logic [3:0] gf4_sq(input logic [3:0] q);
        return {q[3], q[3] ^ q[2], q[2] ^ q[1], q[3] ^ q[1] ^ q[0]};
    endfunction

    // GF(2^4) multiply by the constant lambda
    function automatic logic [3:0] gf4_mul_lambda(input logic [3:0] q);
        return {q[2] ^ q[0], q[3] ^ q[2] ^ q[1] ^ q[0], q[3], q[2]};
    endfunction

    // GF(2^4) multiplicative inverse; inverse of 0 comes out as 0
    function automatic logic [3:0] gf4_inv(input logic [3:0] q);
        logic [3:0] x;
        x[3] = q[3] ^ (q[3] & q[2] & q[1]) ^ (q[3] & q[0]) ^ q[2];
        x[2] = (q[3] & q[2] & q[1]) ^ (q[3] & q[2] & q[0]) ^ (q[3] & q[0]) ^ q[2] ^ (q[2] & q[1]);
        x[1] = q[3] ^ (q[3] & q[2] & q[1]) ^ (q[3] & q[1] & q[0]) ^ q[2] ^ (q[2] & q[0]) ^ q[1];
        x[0] = (q[3] & q[2] & q[1]) ^ (q[3] & q[2] & q[0]) ^ (q[3] & q[1]) ^ (q[3] & q[1] & q[0])
             ^ (q[3] & q[0]) ^ q[2] ^ (q[2] & q[1]) ^ (q[2] & q[1] & q[0]) ^ q[1] ^ q[0];
        return x;
    endfunction

    // GF(2^8) -> GF((2^4)^2) isomorphism
    function automatic logic [7:0] iso_map(input logic [7:0] q);
        logic [7:0] d;
        d[7] = q[7] ^ q[5];
        d[6] = q[7] ^ q[6] ^ q[4] ^ q[3] ^ q[2] ^ q[1];
        d[5] = q[7] ^ q[5] ^ q[3] ^ q[2];
        d[4] = q[7] ^ q[5] ^ q[3] ^ q[2] ^ q[1];
        d[3] = q[7] ^ q[6] ^ q[2] ^ q[1];
        d[2] = q[7] ^ q[4] ^ q[3] ^ q[2] ^ q[1];
        d[1] = q[6] ^ q[4] ^ q[1];
        d[0] = q[6] ^ q[1] ^ q[0];
        return d;
    endfunction

    // GF((2^4)^2) -> GF(2^8) isomorphism
    function automatic logic [7:0] inv_iso_map(input logic [7:0] d);
        logic [7:0] q;
        q[7] = d[7] ^ d[6] ^ d[5] ^ d[1];
        q[6] = d[6] ^ d[2];
        q[5] = d[6] ^ d[5] ^ d[1];
        q[4] = d[6] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
        q[3] = d[5] ^ d[4] ^ d[3] ^ d[2] ^ d[1];
        q[2] = d[7] ^ d[4] ^ d[3] ^ d[2] ^ d[1];
        q[1] = d[5] ^ d[4];
        q[0] = d[6] ^ d[5] ^ d[4] ^ d[2] ^ d[0];
        return q;
    endfunction

    // Forward affine: x ^ rotl1..rotl4 ^ 0x63
    function automatic logic [7:0] affine(input logic [7:0] x);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

    // Inverse affine: rotl1 ^ rotl3 ^ rotl6 ^ 0x05
    function automatic logic [7:0] inv_affine(input logic [7:0] x);
        return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    endfunction

    // Front segment per lane: {qH, qH^qL, value to invert}
    function automatic logic [MW-1:0] front_lanes(input logic [DW-1:0] data, input logic inv);
        logic [MW-1:0] r;
        logic [7:0]    b, d;
        logic [3:0]    qh, ql;
        r = '0;
        for (int k = 0; k < LANES; k++) begin
            b  = data[8*k +: 8];
            if (inv) b = inv_affine(b);
            d  = iso_map(b);
            qh = d[7:4];
            ql = d[3:0];
            r[12*k +: 12] = {qh, qh ^ ql, gf4_mul_lambda(gf4_sq(qh)) ^ gf4_mul(qh ^ ql, ql)};
        end
        return r;
    endfunction

    // Middle segment per lane: replace the low nibble by its GF(2^4) inverse
    function automatic logic [MW-1:0] mid_lanes(input logic [MW-1:0] s);
        logic [MW-1:0] r;
        r = s;
        for (int k = 0; k < LANES; k++) begin
            r[12*k +: 4] = gf4_inv(s[12*k +: 4]);
        end
        return r;
    endfunction

    // Back segment per lane: finish the inverse, map back, forward affine if encrypting
    function automatic logic [DW-1:0] back_lanes(input logic [MW-1:0] s, input logic inv);
        logic [DW-1:0] r;
        logic [7:0]    b;
        logic [3:0]    x;
        r = '0;
        for (int k = 0; k < LANES; k++) begin
            x = s[12*k +: 4];
            b = inv_iso_map({gf4_mul(s[12*k+8 +: 4], x), gf4_mul(s[12*k+4 +: 4], x)});
            r[8*k +: 8] = inv ? b : affine(b);
        end
        return r;
    endfunction

    logic                   in_mode;
    logic                   accept;
    logic                   retire;
    logic [PIPE_STAGES-1:0] v;
    logic [PIPE_STAGES-1:0] m;
    logic [PIPE_STAGES-1:0] vin;
    logic [PIPE_STAGES-1:0] min;
    logic [PIPE_STAGES-1:0] rdy;
    logic [MW-1:0]          mid_q [MID_N];
    logic [MW-1:0]          mid_d [MID_N];
    logic [DW-1:0]          out_q;
    logic [DW-1:0]          out_d;
    logic [1:0]             occ_q;

    assign in_mode   = in_inv & INV_EN;
    assign in_ready  = rdy[0];
    assign out_valid = v[PIPE_STAGES-1];
    assign out_data  = out_q;
    assign out_inv   = m[PIPE_STAGES-1];
    assign occupancy = occ_q;
    assign accept    = in_valid & rdy[0];
    assign retire    = v[PIPE_STAGES-1] & out_ready;

    // A stage can take a new entry when it or any stage downstream is empty, or the output retires
    always_comb begin
        rdy = '0;
        for (int i = 0; i < PIPE_STAGES; i++) begin
            rdy[i] = out_ready;
            for (int j = i; j < PIPE_STAGES; j++) begin
                if (!v[j]) rdy[i] = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < PIPE_STAGES; g++) begin : g_stage
        if (g == 0) begin : g_src_in
            assign vin[g] = in_valid;
            assign min[g] = in_mode;
        end else begin : g_src_prev
            assign vin[g] = v[g-1];
            assign min[g] = m[g-1];
        end

        // Valid and mode bit travel together; the mode only loads with a real entry
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                v[g] <= 1'b0;
                m[g] <= 1'b0;
            end else if (rdy[g]) begin
                v[g] <= vin[g];
                if (vin[g]) m[g] <= min[g];
            end
        end
    end

    for (genvar g = 0; g < PIPE_STAGES - 1; g++) begin : g_mid
        // Intermediate datapath register, held when no valid entry arrives
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                mid_q[g] <= '0;
            end else if (rdy[g] && vin[g]) begin
                mid_q[g] <= mid_d[g];
            end
        end
    end

    if (PIPE_STAGES == 1) begin : g_p1
        assign out_d = back_lanes(mid_lanes(front_lanes(in_data, in_mode)), in_mode);
    end else if (PIPE_STAGES == 2) begin : g_p2
        assign mid_d[0] = front_lanes(in_data, in_mode);
        assign out_d    = back_lanes(mid_lanes(mid_q[0]), m[0]);
    end else begin : g_p3
        assign mid_d[0] = front_lanes(in_data, in_mode);
        assign mid_d[1] = mid_lanes(mid_q[0]);
        assign out_d    = back_lanes(mid_q[1], m[1]);
    end

    // Output register, held stable while stalled or empty
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q <= '0;
        end else if (rdy[PIPE_STAGES-1] && vin[PIPE_STAGES-1]) begin
            out_q <= out_d;
        end
    end

    // In-flight counter: up on accept, down on retire, unchanged when both happen
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_q <= 2'd0;
        end else if (accept && !retire) begin
            occ_q <= occ_q + 2'd1;
        end else if (!accept && retire) begin
            occ_q <= occ_q - 2'd1;
        end
    end
endmodule

// File: tb/tb_sub_bytes_pipe.sv
// tb_sub_bytes_pipe: scoreboard bench for sub_bytes_pipe with a GF(2^8)
// arithmetic reference model, plus a forward-only single-lane instance.
module tb_sub_bytes_pipe;
    localparam int LANES = 4;
    localparam int P     = 2;
    localparam int DW    = 8 * LANES;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          in_inv = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic          out_inv;
    logic [1:0]    occupancy;

    logic          f_valid = 1'b0;
    logic          f_ready;
    logic [7:0]    f_data = '0;
    logic          f_inv = 1'b0;
    logic          f_out_valid;
    logic          f_out_ready = 1'b1;
    logic [7:0]    f_out_data;
    logic          f_out_inv;
    logic [1:0]    f_occ;

    always #5 clk = ~clk;

    sub_bytes_pipe #(.LANES(LANES), .PIPE_STAGES(P), .INV_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_inv(out_inv), .occupancy(occupancy)
    );

    sub_bytes_pipe #(.LANES(1), .PIPE_STAGES(1), .INV_EN(1'b0)) dut_fwd (
        .clk(clk), .reset(reset), .in_valid(f_valid), .in_ready(f_ready),
        .in_data(f_data), .in_inv(f_inv), .out_valid(f_out_valid), .out_ready(f_out_ready),
        .out_data(f_out_data), .out_inv(f_out_inv), .occupancy(f_occ)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          inv;
        int            cyc;
    } exp_t;

    exp_t          sb[$];
    logic [7:0]    sbox_t [256];
    logic [7:0]    inv_t [256];
    int            n_checks = 0;
    int            n_fail = 0;
    int            cycle = 0;
    int            last_stall = -1;
    logic          hold_prev = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_inv = 1'b0;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        logic [7:0] c = 8'h63;
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8] ^ c[i];
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] modelSub(input logic [DW-1:0] d, input logic inv);
        logic [DW-1:0] r;
        for (int k = 0; k < LANES; k++) begin
            r[8*k +: 8] = inv ? inv_t[d[8*k +: 8]] : sbox_t[d[8*k +: 8]];
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Scoreboard: retire against the model queue, then record new accepts
    always @(negedge clk) begin
        exp_t e;
        cycle++;
        if (reset) begin
            sb.delete();
            hold_prev = 1'b0;
            checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
            checkOutput("reset_occupancy", 64'(occupancy), 64'd0);
        end else begin
            checkOutput("occupancy", 64'(occupancy), 64'(sb.size()));
            checkOutput("in_ready", 64'(in_ready), 64'((sb.size() < P) || out_ready));
            if (hold_prev) begin
                checkOutput("stall_out_valid", 64'(out_valid), 64'd1);
                checkOutput("stall_out_data", 64'(out_data), 64'(prev_data));
                checkOutput("stall_out_inv", 64'(out_inv), 64'(prev_inv));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("out_valid_with_nothing_in_flight", 64'(out_valid), 64'd0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("out_data", 64'(out_data), 64'(e.data));
                    checkOutput("out_inv", 64'(out_inv), 64'(e.inv));
                    if (last_stall < e.cyc) checkOutput("latency", 64'(cycle - e.cyc), 64'(P));
                end
            end
            if (in_valid && in_ready) begin
                e.data = modelSub(in_data, in_inv);
                e.inv  = in_inv;
                e.cyc  = cycle;
                sb.push_back(e);
            end
            hold_prev = out_valid && !out_ready;
            prev_data = out_data;
            prev_inv  = out_inv;
            if (!out_ready) last_stall = cycle;
        end
    end

    task automatic applyStimulus(input logic [DW-1:0] data, input logic inv);
        bit acc = 1'b0;
        in_valid = 1'b1;
        in_data  = data;
        in_inv   = inv;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready && !reset;
            @(posedge clk);
            #1;
        end
        if (!acc) checkOutput("accept_timeout", 64'(in_ready), 64'd1);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 50 && sb.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checkOutput("drain_occupancy", 64'(occupancy), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0]    iv;
        logic [DW-1:0] d;
        bit            seen;

        for (int a = 0; a < 256; a++) begin
            iv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (gmul(8'(a), 8'(b)) == 8'h01) iv = 8'(b);
            end
            sbox_t[a] = affine(iv);
        end
        for (int a = 0; a < 256; a++) inv_t[sbox_t[a]] = 8'(a);

        checkOutput("model_sbox_00", 64'(sbox_t[8'h00]), 64'h63);
        checkOutput("model_sbox_01", 64'(sbox_t[8'h01]), 64'h7C);
        checkOutput("model_sbox_53", 64'(sbox_t[8'h53]), 64'hED);
        checkOutput("model_inv_16", 64'(inv_t[8'h16]), 64'hFF);

        // Reset state
        @(negedge clk);
        checkOutput("reset_out_data", 64'(out_data), 64'd0);
        checkOutput("reset_out_inv", 64'(out_inv), 64'd0);
        checkOutput("fwd_reset_out_valid", 64'(f_out_valid), 64'd0);
        checkOutput("fwd_reset_out_data", 64'(f_out_data), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("in_ready_after_reset", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // T1 forward literal
        applyStimulus(32'hFF_53_04_00, 1'b0);
        in_valid = 1'b0;
        repeat (P - 1) @(posedge clk);
        @(negedge clk);
        checkOutput("t1_out_valid", 64'(out_valid), 64'd1);
        checkOutput("t1_out_data", 64'(out_data), 64'h16_ED_F2_63);
        checkOutput("t1_out_inv", 64'(out_inv), 64'd0);
        @(posedge clk);
        #1;

        // T2 inverse literal
        applyStimulus(32'h16_ED_F2_63, 1'b1);
        in_valid = 1'b0;
        repeat (P - 1) @(posedge clk);
        @(negedge clk);
        checkOutput("t2_out_valid", 64'(out_valid), 64'd1);
        checkOutput("t2_out_data", 64'(out_data), 64'hFF_53_04_00);
        checkOutput("t2_out_inv", 64'(out_inv), 64'd1);
        @(posedge clk);
        #1;

        // T3 exhaustive, alternating modes, back-to-back
        $display("[TB] exhaustive stream");
        for (int i = 0; i < 256; i++) begin
            for (int k = 0; k < LANES; k++) d[8*k +: 8] = 8'(i + 37 * k);
            applyStimulus(d, 1'(i & 1));
        end
        drain();

        // T4 stall with input held valid
        $display("[TB] stall test");
        for (int c = 0; c < 40; c++) begin
            in_valid  = 1'b1;
            in_data   = DW'($urandom);
            in_inv    = 1'($urandom_range(0, 1));
            out_ready = !(c >= 10 && c < 15);
            if (c == 14) begin
                @(negedge clk);
                checkOutput("t4_stall_occupancy", 64'(occupancy), 64'(P));
                checkOutput("t4_stall_in_ready", 64'(in_ready), 64'd0);
            end
            @(posedge clk);
            #1;
        end
        drain();

        // Random traffic with random backpressure
        $display("[TB] random traffic");
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = DW'($urandom);
            in_inv    = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        drain();

        // T5 reset with two in flight
        $display("[TB] reset mid-operation");
        out_ready = 1'b0;
        applyStimulus(32'h01_02_03_04, 1'b0);
        applyStimulus(32'hA5_5A_C3_3C, 1'b1);
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("t5_out_valid", 64'(out_valid), 64'd0);
        checkOutput("t5_occupancy", 64'(occupancy), 64'd0);
        checkOutput("t5_out_data", 64'(out_data), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        applyStimulus(32'hFF_53_04_00, 1'b0);
        in_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = out_valid;
        end
        checkOutput("t5_first_out_valid", 64'(out_valid), 64'd1);
        checkOutput("t5_first_out_data", 64'(out_data), 64'h16_ED_F2_63);
        @(posedge clk);
        #1;
        drain();

        // T6 forward-only single-lane instance ignores in_inv
        $display("[TB] forward-only instance");
        f_valid = 1'b1;
        f_inv   = 1'b1;
        f_data  = 8'h53;
        @(negedge clk);
        checkOutput("t6_in_ready", 64'(f_ready), 64'd1);
        @(posedge clk);
        #1;
        f_valid = 1'b0;
        @(negedge clk);
        checkOutput("t6_out_valid", 64'(f_out_valid), 64'd1);
        checkOutput("t6_out_data", 64'(f_out_data), 64'hED);
        checkOutput("t6_out_inv", 64'(f_out_inv), 64'd0);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            f_valid = 1'b1;
            f_inv   = 1'($urandom_range(0, 1));
            f_data  = 8'($urandom);
            @(posedge clk);
            #1;
            f_valid = 1'b0;
            @(negedge clk);
            checkOutput("t6_rand_out_data", 64'(f_out_data), 64'(sbox_t[f_data]));
            checkOutput("t6_rand_out_inv", 64'(f_out_inv), 64'd0);
        end
        @(posedge clk);
        #1;

        checkOutput("final_scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
